// File: rtl/div_ctrl_pkg.sv
// Shared constants for the DIV/DIVU sequencer and the ALU it borrows.
package div_ctrl_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StIter,
    StFix,
    StDone
  } div_state_e;

  // Two's-complement negation, kept local to the divider.
  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

endpackage

// File: rtl/div_ctrl_alu.sv
// 32-bit execute-stage ALU (and/or/add/sub/slt); the divider uses only subtract.
module alu
  import div_ctrl_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [31:0] y,
  output logic        overflow,
  output logic        zero
);

  logic [31:0] b_eff;
  logic [31:0] sum;

  // op[2] selects subtraction as a + ~b + 1.
  assign b_eff    = op[2] ? ~b : b;
  assign sum      = a + b_eff + {31'd0, op[2]};
  assign overflow = (a[31] == b_eff[31]) && (sum[31] != a[31]);

  always_comb begin
    y = '0;
    case (op)
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_ADD: y = sum;
      ALU_SUB: y = sum;
      ALU_SLT: y = {31'd0, sum[31] ^ overflow};
      default: y = '0;
    endcase
  end

  assign zero = (y == 32'd0);

endmodule

// File: rtl/div_ctrl.sv
// Iterative restoring DIV/DIVU sequencer: 32 subtract steps on a shared ALU,
// remainder to hi, quotient to lo, busy/done handshake for the EX stall.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  div_state_e       state_q, state_d;
  logic [4:0]       count_q;
  logic [WIDTH-1:0] r_q, q_q, dmag_q;
  logic             qneg_q, rneg_q, sgn_q;

  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] alu_a, alu_b, alu_y;
  logic [2:0]       alu_op;
  logic             borrow;
  logic             alu_ovf, alu_zero;
  logic             unused_alu_flags;

  alu u_alu (
    .a        (alu_a),
    .b        (alu_b),
    .op       (alu_op),
    .y        (alu_y),
    .overflow (alu_ovf),
    .zero     (alu_zero)
  );

  assign unused_alu_flags = alu_ovf ^ alu_zero;

  assign rs = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
  // Unsigned rs < |b| recovered from the ALU difference and the operand MSBs.
  assign borrow = (~rs[WIDTH-1] & dmag_q[WIDTH-1]) |
                  (~(rs[WIDTH-1] ^ dmag_q[WIDTH-1]) & alu_y[WIDTH-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (cancel) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_d = (b == '0) ? StDone : StPrep;
          end else begin
            state_d = StIdle;
          end
        end
        StPrep: state_d = StIter;
        StIter: if (count_q == 5'd31) state_d = StFix;
        StFix:  state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    busy   = (state_q == StPrep) || (state_q == StIter) || (state_q == StFix);
    done   = (state_q == StDone);
    alu_a  = '0;
    alu_b  = '0;
    alu_op = ALU_ADD;
    if (state_q == StIter) begin
      alu_a  = rs;
      alu_b  = dmag_q;
      alu_op = ALU_SUB;
    end
  end

  // q and dmag first hold the raw operands, then their magnitudes after PREP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      r_q      <= '0;
      q_q      <= '0;
      dmag_q   <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      sgn_q    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else if (!cancel) begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            sgn_q  <= signed_div;
            q_q    <= a;
            dmag_q <= b;
            if (b == '0) begin
              hi       <= '0;
              lo       <= '0;
              div_zero <= 1'b1;
            end else begin
              div_zero <= 1'b0;
            end
          end
        end
        StPrep: begin
          qneg_q  <= sgn_q & (q_q[WIDTH-1] ^ dmag_q[WIDTH-1]);
          rneg_q  <= sgn_q & q_q[WIDTH-1];
          q_q     <= (sgn_q & q_q[WIDTH-1]) ? neg32(q_q) : q_q;
          dmag_q  <= (sgn_q & dmag_q[WIDTH-1]) ? neg32(dmag_q) : dmag_q;
          r_q     <= '0;
          count_q <= '0;
        end
        StIter: begin
          r_q     <= borrow ? rs : alu_y;
          q_q     <= {q_q[WIDTH-2:0], ~borrow};
          count_q <= count_q + 5'd1;
        end
        StFix: begin
          lo <= qneg_q ? neg32(q_q) : q_q;
          hi <= rneg_q ? neg32(r_q) : r_q;
        end
        default: ;
      endcase
    end
  end

endmodule
